// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// latency constants and the combinational arithmetic used at issue time.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    // Low 64 bits of the product of the 64-bit extended operands equal the
    // exact 32x32 product for both signed and unsigned interpretations.
    function automatic logic [63:0] mdu_mul(input logic is_signed,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
        eb = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes, so
    // 0x80000000 / -1 naturally yields quotient 0x80000000, remainder 0.
    // A zero divisor returns the current {hi, lo} so the commit is a no-op.
    function automatic logic [63:0] mdu_div(input logic is_signed,
                                            input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [63:0] cur);
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            return cur;
        end
        ua = (is_signed && a[31]) ? (~a + 32'd1) : a;
        ub = (is_signed && b[31]) ? (~b + 32'd1) : b;
        q  = ua / ub;
        r  = ua % ub;
        if (is_signed && (a[31] ^ b[31])) q = ~q + 32'd1;
        if (is_signed && a[31])           r = ~r + 32'd1;
        return {r, q};
    endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage <-> MDU connection: issue fields in, status and HI/LO results out.
interface mdu_if;
    import mdu_pkg::*;

    logic        start;
    logic [3:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdat;

    modport master (output start, op, opa, opb, input busy, hi, lo, rdat);
    modport slave  (input start, op, opa, opb, output busy, hi, lo, rdat);

endinterface

// File: rtl/mdu.sv
// Multi-cycle MIPS multiply/divide unit: the result is computed at issue,
// held in a pending register and committed to HI/LO after a fixed latency.
module mdu
    import mdu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    mdu_state_e  state_reg;
    logic [3:0]  cnt_reg;
    logic [63:0] pending_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        busy_reg;
    mdu_op_e     op_dec;

    assign op_dec = mdu_op_e'(bus.op);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= 4'd0;
            pending_reg <= 64'd0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (op_dec)
                            MDU_MULT, MDU_MULTU: begin
                                pending_reg <= mdu_mul(op_dec == MDU_MULT, bus.opa, bus.opb);
                                cnt_reg     <= MUL_CYCLES;
                                state_reg   <= ST_MUL;
                                busy_reg    <= 1'b1;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                pending_reg <= mdu_div(op_dec == MDU_DIV, bus.opa, bus.opb,
                                                       {hi_reg, lo_reg});
                                cnt_reg     <= DIV_CYCLES;
                                state_reg   <= ST_DIV;
                                busy_reg    <= 1'b1;
                            end
                            MDU_MTHI: hi_reg <= bus.opa;
                            MDU_MTLO: lo_reg <= bus.opa;
                            default: ;
                        endcase
                    end
                end
                // Any start seen here is dropped: the pipeline stalls instead.
                ST_MUL, ST_DIV: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        hi_reg    <= pending_reg[63:32];
                        lo_reg    <= pending_reg[31:0];
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bus.rdat = 32'd0;
        case (op_dec)
            MDU_MFHI: bus.rdat = hi_reg;
            MDU_MFLO: bus.rdat = lo_reg;
            default:  bus.rdat = 32'd0;
        endcase
    end

    assign bus.busy = busy_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus queues expected HI/LO and busy length,
// a negedge monitor checks each commit when busy falls.
module tb_mdu;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_if bus();

    mdu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: count busy-high samples, compare on the falling edge of busy.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else if (bus.busy === 1'b1) begin
            busy_cnt++;
        end else if (busy_cnt > 0) begin
            if (sb.size() == 0) begin
                check("unexpected_commit", 32'(busy_cnt), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, ".hi"}, bus.hi, mon_e.hi);
                check({mon_e.name, ".lo"}, bus.lo, mon_e.lo);
                check({mon_e.name, ".busy_cycles"}, 32'(busy_cnt), 32'(mon_e.cycles));
            end
            busy_cnt = 0;
        end
    end

    task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = MDU_NONE;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((bus.busy !== 1'b0 || sb.size() != 0) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL %s.timeout: busy=%b pending=%0d want idle", name, bus.busy, sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input string name, input mdu_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input int cycles);
        sb.push_back('{name, hi, lo, cycles});
        issue(op, a, b);
        wait_idle(name);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = MDU_NONE;
        bus.opa   = 32'd0;
        bus.opb   = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset.busy", {31'd0, bus.busy}, 32'd0);
        check("reset.hi", bus.hi, 32'd0);
        check("reset.lo", bus.lo, 32'd0);
        check("reset.rdat", bus.rdat, 32'd0);

        run("mult_m3x7",   MDU_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 5);
        run("divu_100_7",  MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10);
        run("div_m7_2",    MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run("div_7_m2",    MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10);
        run("multu_big",   MDU_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        5);
        run("mult_m1xm1",  MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        5);
        run("divu_max_10", MDU_DIVU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 10);
        run("div_ovf",     MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10);

        issue(MDU_MTHI, 32'h12345678, 32'd0);
        bus.op = MDU_MFHI;
        #1;
        check("mfhi.rdat", bus.rdat, 32'h12345678);
        check("mthi.busy", {31'd0, bus.busy}, 32'd0);
        issue(MDU_MTLO, 32'hCAFEF00D, 32'd0);
        bus.op = MDU_MFLO;
        #1;
        check("mflo.rdat", bus.rdat, 32'hCAFEF00D);
        bus.op = MDU_NONE;
        #1;
        check("none.rdat", bus.rdat, 32'd0);

        issue(MDU_MFHI, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(MDU_NONE, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("nochange.busy", {31'd0, bus.busy}, 32'd0);
        check("nochange.hi", bus.hi, 32'h12345678);
        check("nochange.lo", bus.lo, 32'hCAFEF00D);

        // Second start during busy must be dropped; operand changes too.
        sb.push_back('{"multu_ignore", 32'd1, 32'hFFFFFFFE, 5});
        issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2);
        issue(MDU_DIV, 32'd9, 32'd3);
        bus.opa = 32'hDEADBEEF;
        bus.opb = 32'h0;
        wait_idle("multu_ignore");

        issue(MDU_MTHI, 32'd5, 32'd0);
        issue(MDU_MTLO, 32'd9, 32'd0);
        run("div_by_zero", MDU_DIV, 32'd123, 32'd0, 32'd5, 32'd9, 10);

        // Asynchronous reset in the middle of a DIV.
        issue(MDU_DIV, 32'd100, 32'd7);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst.busy", {31'd0, bus.busy}, 32'd0);
        check("async_rst.hi", bus.hi, 32'd0);
        check("async_rst.lo", bus.lo, 32'd0);
        @(negedge clk);
        #1;
        sb.push_back('{"mult_after_rst", 32'd0, 32'd42, 5});
        bus.start = 1'b1;
        bus.op    = MDU_MULT;
        bus.opa   = 32'd6;
        bus.opb   = 32'd7;
        reset     = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = MDU_NONE;
        wait_idle("mult_after_rst");
        repeat (15) @(negedge clk);
        #1;
        check("no_late_commit.hi", bus.hi, 32'd0);
        check("no_late_commit.lo", bus.lo, 32'd42);
        check("no_late_commit.busy", {31'd0, bus.busy}, 32'd0);
        check("scoreboard.empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
